// File: rtl/clint_mc.sv
// clint_mc -- multi-source core-local interrupt controller.
//
// Captures NUM_IRQ edge-triggered sources into a pending register. Each source
// has its own mask bit. The lowest eligible index wins. The block then writes
// mepc, mstatus and mcause in turn, saving or restoring MPIE, and finally
// redirects ex to the trap vector, or back to mepc for an mret.
//
// Optional feature: define CLINT_VECTOR_EN to enable vectored async targets.
// When mtvec[1:0]==01, the target becomes base + 4*code[4:0].
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   irq_i / irq_mask_i       raw interrupt levels / per-source enables
//   global_int_en_i          mstatus.MIE
//   inst_i, inst_addr_i      instruction in id and its address
//   jump_flag_i, jump_addr_i ex redirect in flight
//   csr_mtvec/mepc/mstatus   current CSR values
//   hold_flag_o              pipeline hold request (combinational)
//   we_o, waddr_o, data_o    registered CSR write port
//   int_assert_o, int_addr_o one-cycle redirect pulse and target
//   irq_ack_o, int_id_o      one-hot ack pulse, index of last taken source
module clint_mc #(
    parameter int NUM_IRQ        = 8,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter int IDX_W          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic               global_int_en_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [31:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic [IDX_W-1:0]   int_id_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        MEPC    = 6'b000010,
        MSTATUS = 6'b000100,
        MCAUSE  = 6'b001000,
        MRET_ST = 6'b010000,
        ASSERT  = 6'b100000
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_IRQ-1:0] irq_q_reg, pending_reg, pending_next;
    logic [NUM_IRQ-1:0] rise, eligible;
    logic [31:0]        cause_reg, cause_next, epc_reg, epc_next;
    logic               mret_reg, mret_next, async_reg, async_next;
    logic               we_reg, we_next, assert_reg, assert_next;
    logic [31:0]        waddr_reg, waddr_next, data_reg, data_next;
    logic [31:0]        addr_reg, addr_next;
    logic [NUM_IRQ-1:0] ack_reg, ack_next;
    logic [IDX_W-1:0]   id_reg, id_next, win_idx;
    logic               win_valid, in_idle, is_sync, take_sync, take_async, take_mret;
    logic [31:0]        ms_trap, ms_mret, trap_base, trap_target;

    // An edge that arrives in the same cycle as an ack wins, so it is not lost.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            assign rise[gi]         = irq_i[gi] & ~irq_q_reg[gi];
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~ack_reg[gi]);
            assign eligible[gi]     = pending_reg[gi] & irq_mask_i[gi] & global_int_en_i;
        end
    endgenerate

    // The loop scans downward, so the last hit is the lowest index.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    // Arbitration is blocked while the redirect pulse is out. This gives ex
    // one clean cycle before the next trap can start.
    assign in_idle    = (state_reg == IDLE) & ~assert_reg;
    assign is_sync    = (inst_i == INST_ECALL) | (inst_i == INST_EBREAK);
    assign take_sync  = in_idle & is_sync;
    assign take_async = in_idle & ~is_sync & win_valid;
    assign take_mret  = in_idle & ~is_sync & ~win_valid & (inst_i == INST_MRET);

    assign hold_flag_o = take_sync | take_async | take_mret | (state_reg != IDLE) | assert_reg;

    // On a trap, MPIE takes MIE and MIE is cleared. On mret, MIE takes MPIE and MPIE is set.
    assign ms_trap = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4], 1'b0, csr_mstatus[2:0]};
    assign ms_mret = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4], csr_mstatus[7], csr_mstatus[2:0]};

    assign trap_base = {csr_mtvec[31:2], 2'b00};
`ifdef CLINT_VECTOR_EN
    assign trap_target = ((csr_mtvec[1:0] == 2'b01) && async_reg)
                       ? trap_base + {25'h0, cause_reg[4:0], 2'b00} : trap_base;
`else
    assign trap_target = trap_base;
    logic unused_vec;
    assign unused_vec = ^{csr_mtvec[1:0], async_reg};
`endif

    always_comb begin
        state_next  = state_reg;
        cause_next  = cause_reg;
        epc_next    = epc_reg;
        mret_next   = mret_reg;
        async_next  = async_reg;
        id_next     = id_reg;
        we_next     = 1'b0;
        waddr_next  = 32'h0;
        data_next   = 32'h0;
        assert_next = 1'b0;
        addr_next   = 32'h0;
        ack_next    = '0;
        case (state_reg)
            IDLE: begin
                if (take_sync) begin
                    cause_next = (inst_i == INST_EBREAK) ? 32'd3 : 32'd11;
                    epc_next   = jump_flag_i ? jump_addr_i - 32'd4 : inst_addr_i;
                    async_next = 1'b0;
                    mret_next  = 1'b0;
                    state_next = MEPC;
                end else if (take_async) begin
                    cause_next = 32'h8000_0000 | 32'(IRQ_CAUSE_BASE + int'(win_idx));
                    epc_next   = jump_flag_i ? jump_addr_i : inst_addr_i;
                    async_next = 1'b1;
                    mret_next  = 1'b0;
                    ack_next   = NUM_IRQ'(1) << win_idx;
                    id_next    = win_idx;
                    state_next = MEPC;
                end else if (take_mret) begin
                    mret_next  = 1'b1;
                    async_next = 1'b0;
                    state_next = MRET_ST;
                end
            end
            MEPC: begin
                we_next    = 1'b1;
                waddr_next = {20'h0, CSR_MEPC};
                data_next  = epc_reg;
                state_next = MSTATUS;
            end
            MSTATUS: begin
                we_next    = 1'b1;
                waddr_next = {20'h0, CSR_MSTATUS};
                data_next  = ms_trap;
                state_next = MCAUSE;
            end
            MCAUSE: begin
                we_next    = 1'b1;
                waddr_next = {20'h0, CSR_MCAUSE};
                data_next  = cause_reg;
                state_next = ASSERT;
            end
            MRET_ST: begin
                we_next    = 1'b1;
                waddr_next = {20'h0, CSR_MSTATUS};
                data_next  = ms_mret;
                state_next = ASSERT;
            end
            ASSERT: begin
                assert_next = 1'b1;
                addr_next   = mret_reg ? csr_mepc : trap_target;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            irq_q_reg   <= '0;
            pending_reg <= '0;
            cause_reg   <= 32'h0;
            epc_reg     <= 32'h0;
            mret_reg    <= 1'b0;
            async_reg   <= 1'b0;
            id_reg      <= '0;
            we_reg      <= 1'b0;
            waddr_reg   <= 32'h0;
            data_reg    <= 32'h0;
            assert_reg  <= 1'b0;
            addr_reg    <= 32'h0;
            ack_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            irq_q_reg   <= irq_i;
            pending_reg <= pending_next;
            cause_reg   <= cause_next;
            epc_reg     <= epc_next;
            mret_reg    <= mret_next;
            async_reg   <= async_next;
            id_reg      <= id_next;
            we_reg      <= we_next;
            waddr_reg   <= waddr_next;
            data_reg    <= data_next;
            assert_reg  <= assert_next;
            addr_reg    <= addr_next;
            ack_reg     <= ack_next;
        end
    end

    assign we_o         = we_reg;
    assign waddr_o      = waddr_reg;
    assign data_o       = data_reg;
    assign int_assert_o = assert_reg;
    assign int_addr_o   = addr_reg;
    assign irq_ack_o    = ack_reg;
    assign int_id_o     = id_reg;

endmodule

// File: tb/tb_clint_mc.sv
// Testbench for clint_mc. It drives a table of single-event vectors, plus
// hand-written sequences for back-to-back sources, masking and a mid-sequence
// reset. Expected CSR writes, acks and redirects go into queues, tagged with
// the cycle they must appear in. A negedge monitor pops and compares them.
module tb_clint_mc;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
`ifdef CLINT_VECTOR_EN
    localparam logic [31:0] TGT_IRQ3 = 32'h0000_104C;
    localparam logic [31:0] TGT_IRQ7 = 32'h0000_105C;
`else
    localparam logic [31:0] TGT_IRQ3 = 32'h0000_1000;
    localparam logic [31:0] TGT_IRQ7 = 32'h0000_1000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_i = 8'h0, irq_mask_i = 8'h0;
    logic        global_int_en_i = 1'b0;
    logic [31:0] inst_i = NOP, inst_addr_i = 32'h0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic [31:0] csr_mtvec = 32'h0, csr_mepc = 32'h0, csr_mstatus = 32'h0;
    logic        hold_flag_o, we_o, int_assert_o;
    logic [31:0] waddr_o, data_o, int_addr_o;
    logic [7:0]  irq_ack_o;
    logic [3:0]  int_id_o;

    clint_mc #(.NUM_IRQ(8), .IRQ_CAUSE_BASE(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .irq_mask_i(irq_mask_i),
        .global_int_en_i(global_int_en_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus), .hold_flag_o(hold_flag_o),
        .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o), .int_id_o(int_id_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;
    exp_t wq[$], aq[$], kq[$];

    typedef struct {
        int          kind;   // 0 sync, 1 async, 2 mret
        logic [31:0] inst, ia;
        logic        jf;
        logic [31:0] ja;
        logic [7:0]  irq, mask;
        logic        mie;
        logic [31:0] mtvec, ms, mepc;
        logic [31:0] e_epc, e_ms, e_cause, e_tgt;
        logic [7:0]  e_ack;
        logic [3:0]  e_id;
    } vec_t;
    vec_t vecs[8];

    int n_cmp = 0, n_fail = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input int c, input logic [31:0] a, input logic [31:0] d);
        wq.push_back('{c, a, d});
    endtask

    task automatic push_trap(input int t0, input logic [31:0] epc, input logic [31:0] ms,
                             input logic [31:0] cause, input logic [31:0] tgt,
                             input logic [7:0] ack, input logic [3:0] id);
        if (ack != 8'h0) kq.push_back('{t0 + 1, {28'h0, id}, {24'h0, ack}});
        push_w(t0 + 2, 32'h341, epc);
        push_w(t0 + 3, 32'h300, ms);
        push_w(t0 + 4, 32'h342, cause);
        aq.push_back('{t0 + 5, 32'h0, tgt});
    endtask

    task automatic chk_drained(input string nm);
        chk(nm, {32'(wq.size()), 32'(aq.size()), 32'(kq.size())}, 96'h0);
    endtask

    // Scoreboard monitor: every output event must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (we_o) begin
                if (wq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL csr_write: got addr %h data %h at cycle %0d, required no write", waddr_o, data_o, cyc);
                end else begin
                    e = wq.pop_front();
                    chk("csr_write", {32'(cyc), waddr_o, data_o}, {32'(e.cyc), e.a, e.d});
                end
            end else begin
                chk("csr_bus_idle", {32'h0, waddr_o, data_o}, 96'h0);
            end
            if (int_assert_o) begin
                if (aq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL int_assert: got pulse addr %h at cycle %0d, required none", int_addr_o, cyc);
                end else begin
                    e = aq.pop_front();
                    chk("int_assert", {32'(cyc), 32'h0, int_addr_o}, {32'(e.cyc), 32'h0, e.d});
                end
            end else begin
                chk("int_addr_idle", {64'h0, int_addr_o}, 96'h0);
            end
            if (irq_ack_o != 8'h0) begin
                if (kq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL irq_ack: got %h at cycle %0d, required none", irq_ack_o, cyc);
                end else begin
                    e = kq.pop_front();
                    chk("irq_ack", {32'(cyc), 24'h0, irq_ack_o, 28'h0, int_id_o},
                                   {32'(e.cyc), 24'h0, e.d[7:0], 28'h0, e.a[3:0]});
                end
            end
        end
    end

    task automatic run_vec(input int n, input vec_t v);
        int t0, last;
        irq_mask_i = v.mask; global_int_en_i = v.mie;
        csr_mtvec = v.mtvec; csr_mstatus = v.ms; csr_mepc = v.mepc;
        inst_addr_i = v.ia; jump_flag_i = v.jf; jump_addr_i = v.ja; inst_i = NOP;
        if (v.irq != 8'h0) begin
            irq_i = v.irq;
            tick();
        end
        inst_i = v.inst;
        t0 = cyc;
        if (v.kind == 2) begin
            push_w(t0 + 2, 32'h300, v.e_ms);
            aq.push_back('{t0 + 3, 32'h0, v.e_tgt});
            last = 3;
        end else begin
            push_trap(t0, v.e_epc, v.e_ms, v.e_cause, v.e_tgt, v.e_ack, v.e_id);
            last = 5;
        end
        for (int k = 0; k <= last + 1; k++) begin
            @(negedge clk);
            chk($sformatf("hold_v%0d_k%0d", n, k), {95'h0, hold_flag_o}, {95'h0, (k <= last)});
            tick();
            if (k == 0) begin
                inst_i = NOP;
                jump_flag_i = 1'b0;
            end
        end
        chk_drained($sformatf("drained_v%0d", n));
        irq_i = 8'h0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        //            kind inst    ia            jf    ja            irq    mask   mie   mtvec         ms            mepc          e_epc         e_ms          e_cause       e_tgt         ack    id
        vecs[0] = '{0, ECALL,  32'h100, 1'b0, 32'h0,   8'h00, 8'hFF, 1'b1, 32'h80,   32'h8,  32'h0,   32'h100, 32'h80, 32'd11,        32'h80,   8'h00, 4'd0};
        vecs[1] = '{0, EBREAK, 32'h300, 1'b1, 32'h200, 8'h00, 8'hFF, 1'b1, 32'h80,   32'h88, 32'h0,   32'h1FC, 32'h80, 32'd3,         32'h80,   8'h00, 4'd0};
        vecs[2] = '{1, NOP,    32'h400, 1'b0, 32'h0,   8'h08, 8'hFF, 1'b1, 32'h1001, 32'h8,  32'h0,   32'h400, 32'h80, 32'h8000_0013, TGT_IRQ3, 8'h08, 4'd3};
        vecs[3] = '{1, NOP,    32'h404, 1'b1, 32'h200, 8'h01, 8'hFF, 1'b1, 32'h2000, 32'h0,  32'h0,   32'h200, 32'h0,  32'h8000_0010, 32'h2000, 8'h01, 4'd0};
        vecs[4] = '{2, MRET,   32'h0,   1'b0, 32'h0,   8'h00, 8'hFF, 1'b1, 32'h80,   32'h80, 32'h344, 32'h0,   32'h88, 32'h0,         32'h344,  8'h00, 4'd0};
        vecs[5] = '{0, ECALL,  32'h0,   1'b1, 32'h500, 8'h00, 8'hFF, 1'b1, 32'h1001, 32'h0,  32'h0,   32'h4FC, 32'h0,  32'd11,        32'h1000, 8'h00, 4'd0};
        vecs[6] = '{2, MRET,   32'h0,   1'b0, 32'h0,   8'h00, 8'hFF, 1'b1, 32'h80,   32'h0,  32'h10,  32'h0,   32'h80, 32'h0,         32'h10,   8'h00, 4'd0};
        vecs[7] = '{1, NOP,    32'h600, 1'b0, 32'h0,   8'h80, 8'hFF, 1'b1, 32'h1001, 32'h88, 32'h0,   32'h600, 32'h80, 32'h8000_0017, TGT_IRQ7, 8'h80, 4'd7};

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("reset_bus", {waddr_o, data_o, int_addr_o}, 96'h0);
        chk("reset_ctl", {83'h0, we_o, int_assert_o, hold_flag_o, irq_ack_o, int_id_o}, 96'h0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Sources 2 and 5 rise together: 2 first, 5 once the redirect has gone out
        irq_mask_i = 8'hFF; global_int_en_i = 1'b1; csr_mtvec = 32'h80; csr_mstatus = 32'h8;
        inst_addr_i = 32'h700; irq_i = 8'h24;
        tick();
        t0 = cyc;
        push_trap(t0,     32'h700, 32'h80, 32'h8000_0012, 32'h80, 8'h04, 4'd2);
        push_trap(t0 + 6, 32'h700, 32'h80, 32'h8000_0015, 32'h80, 8'h20, 4'd5);
        repeat (14) tick();
        chk_drained("drained_two_src");
        chk("int_id_after_two_src", {92'h0, int_id_o}, {92'h0, 4'd5});
        irq_i = 8'h0;
        tick();

        // Reset while in MSTATUS: only the mepc write survives, pending is dropped
        inst_addr_i = 32'h800; inst_i = ECALL;
        t0 = cyc;
        push_w(t0 + 2, 32'h341, 32'h800);
        tick();
        inst_i = NOP; irq_i = 8'h10;
        tick();
        rst = 1'b1; irq_i = 8'h0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midseq_reset_bus", {waddr_o, data_o, int_addr_o}, 96'h0);
        chk("midseq_reset_ctl", {83'h0, we_o, int_assert_o, hold_flag_o, irq_ack_o, int_id_o}, 96'h0);
        repeat (8) tick();
        chk_drained("drained_midseq_reset");

        // Masked source stays quiet until its mask bit opens
        irq_mask_i = 8'hFD; inst_addr_i = 32'h900; irq_i = 8'h02;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("masked_hold_k%0d", k), {95'h0, hold_flag_o}, 96'h0);
            tick();
        end
        irq_mask_i = 8'hFF;
        t0 = cyc;
        push_trap(t0, 32'h900, 32'h80, 32'h8000_0011, 32'h80, 8'h02, 4'd1);
        repeat (8) tick();
        chk_drained("drained_unmask");
        irq_i = 8'h0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_mc.md
Name: clint_mc

Overview:
- Parametrised, multi-source successor to the core-local interrupt arbiter.
- Sits between id/ex, ctrl and csr_reg.
- Captures NUM_IRQ edge-triggered interrupt sources into a pending register and masks them per source.
- Picks the winner by fixed priority, sequences the mepc/mstatus/mcause CSR writes with MPIE save/restore, then redirects ex to the trap vector or back to mepc (mret).

Parameters:
- NUM_IRQ, 8, number of external/local interrupt sources (1..16).
- IRQ_CAUSE_BASE, 16, mcause code of source 0. Source i has code IRQ_CAUSE_BASE+i.
- IDX_W, 4, width of int_id_o. Must satisfy 2^IDX_W >= NUM_IRQ.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- irq_i  in  NUM_IRQ  raw interrupt levels; a rising edge sets pending
- irq_mask_i  in  NUM_IRQ  per-source enable (mie image); 1 = enabled
- global_int_en_i  in  1  mstatus.MIE
- inst_i  in  32  instruction in id
- inst_addr_i  in  32  address of inst_i
- jump_flag_i  in  1  ex is redirecting this cycle
- jump_addr_i  in  32  ex redirect target
- csr_mtvec  in  32  mtvec
- csr_mepc  in  32  mepc
- csr_mstatus  in  32  mstatus
- hold_flag_o  out  1  pipeline hold request to ctrl
- we_o  out  1  CSR write enable
- waddr_o  out  32  CSR write address, {20'h0, csr}
- data_o  out  32  CSR write data
- int_assert_o  out  1  one-cycle redirect pulse to ex
- int_addr_o  out  32  redirect target
- irq_ack_o  out  NUM_IRQ  one-hot one-cycle pulse: source taken
- int_id_o  out  IDX_W  index of the last taken async source

Behaviour:
- Reset (sync, rst=1): all outputs 0; state IDLE; pending, irq_q, cause, epc and int_id_o cleared. Reset mid-sequence aborts: no further CSR writes, no int_assert_o.
- Pending: irq_q <= irq_i each cycle. pending[i] sets on irq_i[i] & ~irq_q[i] and clears on irq_ack_o[i]. A set and a clear in the same cycle leave pending[i] = 1.
- Eligible vector: pending & irq_mask_i, qualified by global_int_en_i. Winner is the lowest set index.
- Decision, in IDLE only, priority order:
  - SYNC: inst_i is ECALL (cause 11) or EBREAK (cause 3).
  - ASYNC: eligible vector nonzero; cause 0x80000000 | (IRQ_CAUSE_BASE + idx).
  - MRET: inst_i is MRET.
  - Else stay IDLE.
- Captured epc:
  - SYNC: jump_flag_i ? jump_addr_i-4 : inst_addr_i.
  - ASYNC: jump_flag_i ? jump_addr_i : inst_addr_i.
- ASYNC accept also pulses irq_ack_o[idx] and loads int_id_o, both in the decision cycle T+1 (registered).
- States (one-hot): IDLE, MEPC, MSTATUS, MCAUSE, MRET_ST, ASSERT.
  - Trap: IDLE(T) -> MEPC -> MSTATUS -> MCAUSE -> ASSERT -> IDLE.
  - MRET: IDLE(T) -> MRET_ST -> ASSERT -> IDLE.
- Registered CSR writes, asserted the cycle after each state:
  - T+2: mepc <= epc.
  - T+3: mstatus <= {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]} (MPIE=MIE, MIE=0).
  - T+4: mcause <= cause.
  - MRET, T+2: mstatus <= {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]}.
  - we_o is 0 in all other cycles, with waddr_o/data_o forced to 0.
- int_assert_o: one-cycle pulse at T+5 (trap) or T+3 (mret). int_addr_o is valid only in that cycle, else 0.
  - Trap target: mtvec[1:0]==01 and ASYNC ? {mtvec[31:2],2'b00} + 4*code[4:0] : {mtvec[31:2],2'b00}.
  - MRET target: csr_mepc.
- hold_flag_o = (decision != none in IDLE) | (state != IDLE) | int_assert_o. Combinational.
- New edges arriving during a sequence stay pending and are arbitrated at the next IDLE cycle after int_assert_o.

Optional Feature:
- CLINT_VECTOR_EN defined: the vectored target rule above applies.
- Undefined: always {mtvec[31:2],2'b00}, and mtvec[1:0] is ignored.

Test Plan:
- ECALL at inst_addr_i=0x100, mtvec=0x80, ms=0x8: T+2 mepc=0x100; T+3 mstatus=0x80; T+4 mcause=11; T+5 int_assert_o=1, int_addr_o=0x80; hold high T..T+5.
- irq_i[5] and irq_i[2] rise together, mask=0xFF, MIE=1: source 2 taken first (irq_ack_o=0x04, mcause=0x80000012). Source 5 is taken after the sequence (mcause=0x80000015, int_id_o=5).
- CLINT_VECTOR_EN, mtvec=0x1001, irq 3 (code 19): int_addr_o=0x104C. Without the macro: 0x1000.
- ASYNC with jump_flag_i=1, jump_addr_i=0x200: mepc=0x200. Same case for EBREAK: mepc=0x1FC, mcause=3.
- MRET with ms=0x80, mepc=0x344: T+2 mstatus=0x88; T+3 int_assert_o=1, int_addr_o=0x344.
- Masked pending (mask[1]=0) raises nothing; setting mask[1]=1 later takes it. rst asserted at state MSTATUS: no mcause write, no int_assert_o, pending cleared.
